// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART baud divisors, divisor lookup and TX state type
package uart_pkg;

   localparam logic [12:0] DIV_9600  = 13'd5208;
   localparam logic [12:0] DIV_19200 = 13'd2604;
   localparam logic [12:0] DIV_38400 = 13'd1302;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      STOP
   } tx_state_t;

   // Bit period in 50 MHz clocks for the 2-bit baud select shared with the receiver
   function automatic logic [12:0] baud_div(input logic [1:0] sel);
      case (sel)
         2'b00:   baud_div = DIV_9600;
         2'b01:   baud_div = DIV_19200;
         default: baud_div = DIV_38400;
      endcase
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // A write while full is dropped even if a pop happens in the same cycle
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array, no reset needed since empty entries are never read out
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter with back-to-back frames
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] baud_setting,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       empty,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx
);

   tx_state_t                state;
   logic [12:0]              div_q;
   logic [12:0]              baud_cnt;
   logic [2:0]               bit_cnt;
   logic [7:0]               shift;
   logic [7:0]               fifo_dout;
   logic [$clog2(DEPTH):0]   fifo_count;
   logic                     have_data;
   logic                     bit_end;
   logic                     pop;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr_en),
      .rd_en (pop),
      .din   (wr_data),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign have_data = (fifo_count != '0);
   assign bit_end   = (baud_cnt == div_q - 13'd1);

   // Pop from IDLE, or at the last stop clock so the next start bit follows with no gap
   always_comb begin
      pop = 1'b0;
      if (have_data && (state == IDLE || (state == STOP && bit_end))) pop = 1'b1;
   end

   // Frame sequencer: the show-ahead byte is captured at the pop edge, the divisor at load
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         div_q    <= '0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (have_data) begin
                  shift   <= fifo_dout;
                  tx_busy <= 1'b1;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               div_q    <= baud_div(baud_setting);
               baud_cnt <= '0;
               tx       <= 1'b0;
               state    <= START;
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= shift[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 13'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= bit_cnt + 3'd1;
                  shift    <= {1'b0, shift[7:1]};
                  if (bit_cnt == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     tx <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 13'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  tx_done  <= 1'b1;
                  baud_cnt <= '0;
                  if (have_data) begin
                     shift <= fifo_dout;
                     div_q <= baud_div(baud_setting);
                     tx    <= 1'b0;
                     state <= START;
                  end else begin
                     tx_busy <= 1'b0;
                     state   <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 13'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with timeline reference model
module tb_uart_tx_fifo;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] baud_setting = 2'b00;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       full, empty, tx_busy, tx_done, tx;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int shown = 0;

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .baud_setting (baud_setting),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .empty        (empty),
      .tx_busy      (tx_busy),
      .tx_done      (tx_done),
      .tx           (tx)
   );

   always #10 clk = ~clk;

   // Reference model: a byte queue plus the current frame's start cycle and bit period
   logic [7:0] mq[$];
   bit         m_active = 0;
   bit         m_loading = 0;
   bit         m_done = 0;
   logic [7:0] m_byte = 8'h00;
   int         m_div = 1;
   int         m_t0 = 0;

   function automatic int ref_div(input logic [1:0] s);
      if (s == 2'b00) return 5208;
      if (s == 2'b01) return 2604;
      return 1302;
   endfunction

   function automatic logic m_tx();
      int idx;
      if (!m_active) return 1'b1;
      idx = (cyc - m_t0) / m_div;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return m_byte[idx-1];
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      bit full_pre;
      bit empty_pre;
      cyc = cyc + 1;
      full_pre  = (mq.size() == DEPTH);
      empty_pre = (mq.size() == 0);
      m_done = 0;
      if (rst) begin
         mq.delete();
         m_active  = 0;
         m_loading = 0;
      end else begin
         if (m_active && cyc == m_t0 + 10 * m_div) begin
            m_done = 1;
            if (!empty_pre) begin
               m_byte = mq.pop_front();
               m_t0   = cyc;
               m_div  = ref_div(baud_setting);
            end else begin
               m_active = 0;
            end
         end else if (m_loading) begin
            m_loading = 0;
            m_active  = 1;
            m_t0      = cyc;
            m_div     = ref_div(baud_setting);
         end else if (!m_active && !empty_pre) begin
            m_byte    = mq.pop_front();
            m_loading = 1;
         end
         if (wr_en && !full_pre) mq.push_back(wr_data);
      end
   end

   always @(negedge clk) begin
      logic [4:0] act;
      logic [4:0] exp;
      if (cyc > 0) begin
         act = {tx, tx_busy, tx_done, full, empty};
         exp = {m_tx(), (m_active || m_loading), m_done, (mq.size() == DEPTH), (mq.size() == 0)};
         checks++;
         if (act !== exp) begin
            errors++;
            if (shown < 10) $display("FAIL model cyc=%0d {tx,busy,done,full,empty} got %b want %b", cyc, act, exp);
            shown++;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic wait_done(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (tx_done) begin
            at = cyc;
            break;
         end
      end
      chk("done_seen", (at >= 0) ? 1 : 0, 1);
   endtask

   typedef struct {
      logic       rst;
      logic       wr;
      logic [7:0] d;
      logic       tx;
      logic       empty;
      logic       full;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t vt[9];

   initial begin
      int t_start, t1, td1, td2, bad, ndone;
      vt[0] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[1] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[2] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[5] = '{1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      // Reset with writes held high, then first byte 0x0F at 9600 baud
      t_start = 0;
      for (int i = 0; i < 9; i++) begin
         rst = vt[i].rst;
         wr_en = vt[i].wr;
         wr_data = vt[i].d;
         @(negedge clk);
         chk($sformatf("vec%0d_tx", i), int'(tx), int'(vt[i].tx));
         chk($sformatf("vec%0d_empty", i), int'(empty), int'(vt[i].empty));
         chk($sformatf("vec%0d_full", i), int'(full), int'(vt[i].full));
         chk($sformatf("vec%0d_busy", i), int'(tx_busy), int'(vt[i].busy));
         chk($sformatf("vec%0d_done", i), int'(tx_done), int'(vt[i].done));
         if (i == 7) t_start = cyc;
      end

      // Queue a second byte, then reset in the middle of the data bits
      wr_en = 1'b1;
      wr_data = 8'h77;
      @(negedge clk);
      wr_en = 1'b0;
      chk("queued_empty", int'(empty), 0);
      for (int i = 0; i < 20000; i++) begin
         if (cyc >= t_start + 3 * 5208 + 100) break;
         @(negedge clk);
      end
      chk("mid_data_busy", int'(tx_busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_tx", int'(tx), 1);
      chk("rst_mid_empty", int'(empty), 1);
      chk("rst_mid_busy", int'(tx_busy), 0);
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (tx_done || !tx || tx_busy) bad++;
      end
      chk("no_frame_after_rst", bad, 0);

      // Back-to-back 0xA5, 0x3C at 38400; baud moved to 19200 during the first frame
      baud_setting = 2'b10;
      wr_en = 1'b1;
      wr_data = 8'hA5;
      @(negedge clk);
      wr_data = 8'h3C;
      @(negedge clk);
      wr_en = 1'b0;
      t1 = -1;
      for (int i = 0; i < 10; i++) begin
         if (!tx) begin
            t1 = cyc;
            break;
         end
         @(negedge clk);
      end
      chk("b2b_start_seen", (t1 >= 0) ? 1 : 0, 1);
      repeat (5000) @(negedge clk);
      baud_setting = 2'b01;
      wait_done(14000, td1);
      chk("frame1_len", td1 - t1, 13020);
      chk("frame2_start_now", int'(tx), 0);
      wait_done(27000, td2);
      chk("frame2_len", td2 - td1, 26040);
      chk("after2_tx", int'(tx), 1);
      chk("after2_busy", int'(tx_busy), 0);

      // Overflow: six random bytes on consecutive cycles, then random traffic, then reset
      repeat (5) @(negedge clk);
      baud_setting = 2'b11;
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1;
         wr_data = 8'($urandom_range(0, 255));
         @(negedge clk);
         if (i == 3) chk("full_before_5th", int'(full), 0);
         if (i == 4) chk("full_after_5th", int'(full), 1);
         if (i == 5) chk("full_after_6th", int'(full), 1);
      end
      wr_en = 1'b0;
      ndone = 0;
      for (int i = 0; i < 15000; i++) begin
         wr_en = ($urandom_range(0, 7) == 0);
         wr_data = 8'($urandom_range(0, 255));
         @(negedge clk);
         if (tx_done) ndone++;
      end
      wr_en = 1'b0;
      chk("overflow_done_count", ndone, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("final_rst_tx", int'(tx), 1);
      chk("final_rst_empty", int'(empty), 1);
      repeat (20) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
